// File: rtl/sha3_scanner_control_mc.sv
// sha3_scanner_control_mc
// Multi-lane SHA3-1600 nonce scan controller. Drives LANES hashers in
// lockstep with interleaved nonces (lane l gets scan_start + l + k*LANES).
// Every returned hash is checked against a 64-bit threshold. The first hit
// is recorded together with its absolute nonce and full state. Per-lane
// outstanding counters let the block wait for an exact flush before it
// returns to idle.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              scan request, accepted only while ready
//   abort              stop dispatching (S_DISPATCH only)
//   threshold          hit when byte-swapped hash word0 < threshold
//   block_template     24x32 template, word w at [32w+31:32w]
//   scan_count         nonces to dispatch, 0 means 2^32
//   ready              idle, start accepted
//   dispatching        in S_DISPATCH with every hasher ready
//   evaluating         any lane returning a hash this cycle
//   done               one-cycle pulse on return to idle
//   found/nonce/hash   first recorded hit
//   scanned            hashes evaluated this scan (saturating)
//   hasher_ready       per-lane hasher can accept
//   crunch_sample      per-lane input valid
//   crunch_state       per-lane input state, lane l at [1600l+1599:1600l]
//   hash_sample        per-lane output valid
//   hash_state         per-lane output state
//   scan_cycles        clocks spent scanning (optional feature)
//
// Optional feature macro: SHA3_SCANNER_CYCLE_COUNT_EN enables the
// scan_cycles counter; without it scan_cycles is tied to 0.

module sha3_scanner_control_mc #(
    parameter int LANES   = 2,
    parameter int OUTST_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [63:0]             threshold,
    input  logic [767:0]            block_template,
    input  logic [31:0]             scan_count,
    output logic                    ready,
    output logic                    dispatching,
    output logic                    evaluating,
    output logic                    done,
    output logic                    found,
    output logic [31:0]             nonce,
    output logic [1599:0]           hash,
    output logic [31:0]             scanned,
    input  logic [LANES-1:0]        hasher_ready,
    output logic [LANES-1:0]        crunch_sample,
    output logic [1600*LANES-1:0]   crunch_state,
    input  logic [LANES-1:0]        hash_sample,
    input  logic [1600*LANES-1:0]   hash_state,
    output logic [31:0]             scan_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_FLUSH
    } state_t;

    state_t state;
    state_t state_next;

    // State words 0..11 are exactly the template bits, since word i is
    // {tpl[2i+1], tpl[2i]}.
    logic [767:0]       tpl_words;
    logic [31:0]        scan_start;
    logic [31:0]        next_nonce;
    logic [32:0]        remaining;
    logic [OUTST_W-1:0] outstanding [LANES];
    logic [31:0]        result_idx [LANES];

    logic               all_ready;
    logic               accept;
    logic               stop_dispatch;
    logic               issue;
    logic               outst_zero;
    logic               flush_done;
    logic               hit_any;
    logic [31:0]        hit_nonce;
    logic [1599:0]      hit_hash;
    logic [63:0]        lane_word0;
    logic [63:0]        swapped;
    logic [3:0]         hash_count;
    logic [32:0]        scanned_sum;

    assign ready       = (state == S_IDLE);
    assign dispatching = (state == S_DISPATCH) && all_ready;
    assign evaluating  = |hash_sample;

    // Exit conditions are checked before dispatch, so the cycle that sees
    // them issues nothing.
    always_comb begin
        all_ready     = &hasher_ready;
        accept        = (state == S_IDLE) && start;
        stop_dispatch = (remaining == 33'd0) || found || abort;
        issue         = (state == S_DISPATCH) && all_ready && !stop_dispatch;
        outst_zero    = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            if (outstanding[l] != '0) begin
                outst_zero = 1'b0;
            end
        end
        flush_done = (state == S_FLUSH) && outst_zero && (hash_sample == '0);

        state_next = state;
        case (state)
            S_IDLE:     if (start)         state_next = S_DISPATCH;
            S_DISPATCH: if (stop_dispatch) state_next = S_FLUSH;
            S_FLUSH:    if (flush_done)    state_next = S_IDLE;
            default:                       state_next = S_IDLE;
        endcase
    end

    // Lane input states; only lanes below the remaining count fire on the
    // final partial dispatch.
    always_comb begin
        crunch_sample = '0;
        crunch_state  = '0;
        for (int l = 0; l < LANES; l++) begin
            crunch_sample[l] = issue && (33'(l) < remaining);
            crunch_state[1600*l +: 768]       = tpl_words;
            crunch_state[1600*l + 768 +: 64]  = {32'h00000006, next_nonce + 32'(l)};
            crunch_state[1600*l + 1024 +: 64] = 64'h80000000_00000000;
        end
    end

    // Hit detection. Walking lanes from high to low lets the lowest lane
    // win when several hit together. A lane's absolute nonce follows from
    // how many results it has already returned.
    always_comb begin
        hit_any    = 1'b0;
        hit_nonce  = '0;
        hit_hash   = '0;
        lane_word0 = '0;
        swapped    = '0;
        hash_count = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            lane_word0 = hash_state[1600*l +: 64];
            for (int b = 0; b < 8; b++) begin
                swapped[63 - 8*b -: 8] = lane_word0[8*b +: 8];
            end
            if ((state != S_IDLE) && hash_sample[l] && (swapped < threshold)) begin
                hit_any   = 1'b1;
                hit_nonce = scan_start + 32'(l) + result_idx[l] * 32'(LANES);
                hit_hash  = hash_state[1600*l +: 1600];
            end
        end
        for (int l = 0; l < LANES; l++) begin
            hash_count = hash_count + {3'b000, hash_sample[l]};
        end
        scanned_sum = {1'b0, scanned} + {29'd0, hash_count};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Scan datapath. Results arriving in idle (e.g. after a mid-scan reset)
    // are ignored; the outstanding counters clamp at zero in that case.
    always_ff @(posedge clk) begin
        if (rst) begin
            tpl_words  <= '0;
            scan_start <= '0;
            next_nonce <= '0;
            remaining  <= '0;
            found      <= 1'b0;
            nonce      <= '0;
            hash       <= '0;
            scanned    <= '0;
            done       <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                outstanding[l] <= '0;
                result_idx[l]  <= '0;
            end
        end else begin
            done <= flush_done;
            if (accept) begin
                tpl_words  <= block_template;
                scan_start <= block_template[703:672];
                next_nonce <= block_template[703:672];
                remaining  <= (scan_count == 32'd0) ? 33'h1_0000_0000 : {1'b0, scan_count};
                found      <= 1'b0;
                nonce      <= '0;
                hash       <= '0;
                scanned    <= '0;
                for (int l = 0; l < LANES; l++) begin
                    result_idx[l] <= '0;
                end
            end else begin
                if (issue) begin
                    next_nonce <= next_nonce + 32'(LANES);
                    remaining  <= (remaining > 33'(LANES)) ? remaining - 33'(LANES) : 33'd0;
                end
                if (state != S_IDLE) begin
                    if (hit_any && !found) begin
                        found <= 1'b1;
                        nonce <= hit_nonce;
                        hash  <= hit_hash;
                    end
                    scanned <= scanned_sum[32] ? 32'hFFFFFFFF : scanned_sum[31:0];
                    for (int l = 0; l < LANES; l++) begin
                        if (hash_sample[l]) begin
                            result_idx[l] <= result_idx[l] + 32'd1;
                        end
                    end
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (crunch_sample[l] && !hash_sample[l]) begin
                    outstanding[l] <= outstanding[l] + 1'b1;
                end else if (!crunch_sample[l] && hash_sample[l] && (outstanding[l] != '0)) begin
                    outstanding[l] <= outstanding[l] - 1'b1;
                end
            end
        end
    end

`ifdef SHA3_SCANNER_CYCLE_COUNT_EN
    logic [31:0] cycle_count;

    // Counts clocks outside idle; cleared on an accepted start, saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (accept) begin
            cycle_count <= '0;
        end else if ((state != S_IDLE) && (cycle_count != 32'hFFFFFFFF)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    assign scan_cycles = cycle_count;
`else
    assign scan_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_sha3_scanner_control_mc.sv
// tb_sha3_scanner_control_mc
// Self-checking bench for sha3_scanner_control_mc with LANES=2. A 10-cycle
// hasher pipeline model echoes each lane input state back with word0
// replaced: 0 for nonces marked as hits, all-ones otherwise. A table of
// scan scenarios is run in a loop, followed by hand-written abort and
// mid-flush reset sequences.

module tb_sha3_scanner_control_mc;

    localparam int LANES = 2;
    localparam int PIPE  = 11;
    localparam int LOG_N = 512;
    localparam int NVEC  = 6;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  abort;
    logic [63:0]           threshold;
    logic [767:0]          block_template;
    logic [31:0]           scan_count;
    logic                  ready;
    logic                  dispatching;
    logic                  evaluating;
    logic                  done;
    logic                  found;
    logic [31:0]           nonce;
    logic [1599:0]         hash;
    logic [31:0]           scanned;
    logic [LANES-1:0]      hasher_ready;
    logic [LANES-1:0]      crunch_sample;
    logic [1600*LANES-1:0] crunch_state;
    bit   [LANES-1:0]      hash_sample;
    logic [1600*LANES-1:0] hash_state;
    logic [31:0]           scan_cycles;

    sha3_scanner_control_mc #(.LANES(LANES), .OUTST_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .threshold      (threshold),
        .block_template (block_template),
        .scan_count     (scan_count),
        .ready          (ready),
        .dispatching    (dispatching),
        .evaluating     (evaluating),
        .done           (done),
        .found          (found),
        .nonce          (nonce),
        .hash           (hash),
        .scanned        (scanned),
        .hasher_ready   (hasher_ready),
        .crunch_sample  (crunch_sample),
        .crunch_state   (crunch_state),
        .hash_sample    (hash_sample),
        .hash_state     (hash_state),
        .scan_cycles    (scan_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start_nonce;
        logic [31:0] count;
        logic [63:0] thr;
        logic        hit_a_en;
        logic [31:0] hit_a;
        logic        hit_b_en;
        logic [31:0] hit_b;
        logic        exp_found;
        logic [31:0] exp_nonce;
        int          exp_disp;
        logic [1:0]  exp_mask;
    } scan_vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic        hit_a_en = 1'b0;
    logic [31:0] hit_a    = '0;
    logic        hit_b_en = 1'b0;
    logic [31:0] hit_b    = '0;
    logic        toggle_ready = 1'b0;

    int          cyc = 0;
    int          disp_total = 0;
    int          done_total = 0;
    int          last_hash_cyc = 0;
    int          last_done_cyc = 0;
    int          last_crunch_cyc = 0;
    int          abort_cyc = 0;
    logic [1:0]  last_mask = '0;
    logic [31:0] nonce_log [LOG_N];

    bit          pv [LANES][PIPE];
    logic [1599:0] ps [LANES][PIPE];
    logic [1599:0] model_tmp;

    function automatic logic is_hit(input logic [31:0] n);
        return (hit_a_en && (n == hit_a)) || (hit_b_en && (n == hit_b));
    endfunction

    function automatic logic [767:0] make_tpl(input logic [31:0] start_n);
        logic [767:0] t;
        t = '0;
        for (int w = 0; w < 24; w++) begin
            t[32*w +: 32] = 32'hC0DE0000 | 32'(w);
        end
        t[32*21 +: 32] = start_n;
        return t;
    endfunction

    function automatic logic [1599:0] model_state(input logic [767:0] tpl, input logic [31:0] n);
        logic [1599:0] s;
        s = '0;
        s[767:0]     = tpl;
        s[831:768]   = {32'h00000006, n};
        s[1087:1024] = 64'h80000000_00000000;
        return s;
    endfunction

    // Observes the DUT mid-cycle, then advances the hasher pipeline model.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (hash_sample != '0) begin
            last_hash_cyc = cyc;
        end
        if (crunch_sample != '0) begin
            last_crunch_cyc = cyc;
            last_mask = crunch_sample;
            for (int l = 0; l < LANES; l++) begin
                if (crunch_sample[l]) begin
                    nonce_log[disp_total % LOG_N] = crunch_state[1600*l + 768 +: 32];
                    disp_total = disp_total + 1;
                end
            end
        end
        if (done) begin
            done_total = done_total + 1;
            last_done_cyc = cyc;
        end
        if (abort) begin
            abort_cyc = cyc;
        end
        for (int l = 0; l < LANES; l++) begin
            for (int k = PIPE - 1; k > 0; k--) begin
                pv[l][k] = pv[l][k-1];
                ps[l][k] = ps[l][k-1];
            end
            pv[l][0] = crunch_sample[l];
            ps[l][0] = crunch_state[1600*l +: 1600];
        end
        for (int l = 0; l < LANES; l++) begin
            hash_sample[l] = pv[l][PIPE-1];
            model_tmp = ps[l][PIPE-1];
            model_tmp[63:0] = is_hit(model_tmp[799:768]) ? 64'd0 : 64'hFFFFFFFF_FFFFFFFF;
            hash_state[1600*l +: 1600] = model_tmp;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_ready) begin
            hasher_ready = ~hasher_ready;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkHash(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        int bad;
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            bad = 0;
            for (int w = 24; w >= 0; w--) begin
                if (act[64*w +: 64] !== exp[64*w +: 64]) bad = w;
            end
            $display("[TB] FAIL %s word %0d actual=%h expected=%h", name, bad,
                     act[64*bad +: 64], exp[64*bad +: 64]);
        end
    endtask

    task automatic waitDone(input int base_done, input string name);
        int waited;
        waited = 0;
        while ((done_total == base_done) && (waited < 3000)) begin
            tick();
            waited = waited + 1;
        end
        if (done_total == base_done) begin
            checkOutput(name, 64'd0, 64'd1);
        end
    endtask

    // Runs one table scenario from start to done and checks the result.
    task automatic applyStimulus(input scan_vec_t v, input int idx);
        int base_disp, base_done, bad_i;
        logic [1599:0] exp_hash;
        logic [767:0]  tpl;
        tpl            = make_tpl(v.start_nonce);
        block_template = tpl;
        threshold      = v.thr;
        scan_count     = v.count;
        hit_a_en       = v.hit_a_en;
        hit_a          = v.hit_a;
        hit_b_en       = v.hit_b_en;
        hit_b          = v.hit_b;
        base_disp      = disp_total;
        base_done      = done_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(base_done, "done timeout");
        tick();
        tick();
        $display("[TB] vector %0d start=%h count=%0d", idx, v.start_nonce, v.count);
        checkOutput("ready", {63'd0, ready}, 64'd1);
        checkOutput("found", {63'd0, found}, {63'd0, v.exp_found});
        checkOutput("nonce", {32'd0, nonce}, {32'd0, v.exp_nonce});
        checkOutput("scanned", {32'd0, scanned}, 64'(v.exp_disp));
        checkOutput("dispatched", 64'(disp_total - base_disp), 64'(v.exp_disp));
        checkOutput("last mask", {62'd0, last_mask}, {62'd0, v.exp_mask});
        checkOutput("done count", 64'(done_total - base_done), 64'd1);
        checkOutput("done after drain", {63'd0, last_done_cyc > last_hash_cyc}, 64'd1);
        bad_i = v.exp_disp - 1;
        for (int i = v.exp_disp - 1; i >= 0; i--) begin
            if (nonce_log[(base_disp + i) % LOG_N] !== v.start_nonce + 32'(i)) bad_i = i;
        end
        checkOutput("nonce seq", {32'd0, nonce_log[(base_disp + bad_i) % LOG_N]},
                    {32'd0, v.start_nonce + 32'(bad_i)});
        if (v.exp_found) begin
            exp_hash = model_state(tpl, v.exp_nonce);
            exp_hash[63:0] = 64'd0;
        end else begin
            exp_hash = '0;
        end
        checkHash("hash", hash, exp_hash);
    endtask

    scan_vec_t vecs [NVEC];

    initial begin
        int base_disp, base_done, base_scanned_disp;

        vecs[0] = '{32'h100, 32'd6, 64'd0, 1'b0, 32'd0, 1'b0, 32'd0,
                    1'b0, 32'd0, 6, 2'b11};
        vecs[1] = '{32'h100, 32'd6, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 32'h103, 1'b0, 32'd0,
                    1'b1, 32'h103, 6, 2'b11};
        vecs[2] = '{32'h100, 32'd6, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 32'h104, 1'b1, 32'h105,
                    1'b1, 32'h104, 6, 2'b11};
        vecs[3] = '{32'h100, 32'd5, 64'd0, 1'b0, 32'd0, 1'b0, 32'd0,
                    1'b0, 32'd0, 5, 2'b01};
        vecs[4] = '{32'hFFFFFFFF, 32'd3, 64'd0, 1'b0, 32'd0, 1'b0, 32'd0,
                    1'b0, 32'd0, 3, 2'b01};
        // Unbounded scan: the hit on 0x103 returns 10 cycles after its
        // dispatch, so 12 full dispatches happen before found stops issue.
        vecs[5] = '{32'h100, 32'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 32'h103, 1'b0, 32'd0,
                    1'b1, 32'h103, 24, 2'b11};

        rst            = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        threshold      = '0;
        block_template = '0;
        scan_count     = '0;
        hasher_ready   = '1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        checkOutput("reset ready", {63'd0, ready}, 64'd1);
        checkOutput("reset done", {63'd0, done}, 64'd0);
        checkOutput("reset found", {63'd0, found}, 64'd0);
        checkOutput("reset nonce", {32'd0, nonce}, 64'd0);
        checkOutput("reset scanned", {32'd0, scanned}, 64'd0);
        checkOutput("reset crunch", {62'd0, crunch_sample}, 64'd0);
        checkOutput("reset dispatching", {63'd0, dispatching}, 64'd0);

        for (int v = 0; v < NVEC; v++) begin
            applyStimulus(vecs[v], v);
        end

`ifdef SHA3_SCANNER_CYCLE_COUNT_EN
        checkOutput("scan cycles", {63'd0, scan_cycles > 32'd0}, 64'd1);
`else
        checkOutput("scan cycles", {32'd0, scan_cycles}, 64'd0);
`endif

        // Abort during an unbounded scan with hashers ready half the time.
        $display("[TB] abort sequence");
        block_template = make_tpl(32'h200);
        threshold      = 64'd0;
        scan_count     = 32'd0;
        hit_a_en       = 1'b0;
        hit_b_en       = 1'b0;
        toggle_ready   = 1'b1;
        base_disp      = disp_total;
        base_done      = done_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        waitDone(base_done, "abort done timeout");
        toggle_ready = 1'b0;
        hasher_ready = '1;
        tick();
        tick();
        base_scanned_disp = disp_total - base_disp;
        checkOutput("abort dispatched some", {63'd0, base_scanned_disp > 0}, 64'd1);
        checkOutput("abort no crunch after", {63'd0, last_crunch_cyc < abort_cyc}, 64'd1);
        checkOutput("abort scanned", {32'd0, scanned}, 64'(base_scanned_disp));
        checkOutput("abort done count", 64'(done_total - base_done), 64'd1);
        checkOutput("abort done after drain", {63'd0, last_done_cyc > last_hash_cyc}, 64'd1);
        checkOutput("abort found", {63'd0, found}, 64'd0);

        // Reset while flushing; the late hit on nonce 0 must be ignored.
        $display("[TB] reset mid-flush sequence");
        block_template = make_tpl(32'hFFFFFFFF);
        threshold      = 64'hFFFFFFFF_FFFFFFFF;
        scan_count     = 32'd3;
        hit_a_en       = 1'b1;
        hit_a          = 32'h0;
        base_done      = done_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("flush not ready", {63'd0, ready}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst ready", {63'd0, ready}, 64'd1);
        checkOutput("rst found", {63'd0, found}, 64'd0);
        for (int i = 0; i < 15; i++) tick();
        checkOutput("rst no done", 64'(done_total - base_done), 64'd0);
        checkOutput("rst late found", {63'd0, found}, 64'd0);
        checkOutput("rst late scanned", {32'd0, scanned}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
